// File: rtl/gray_arb_pkg.sv
// Shared types for the two-requester Gray-conversion arbiter.
// The round-robin feature is enabled by the GRAY_ARB_RR_EN macro (see gray_conv_arbiter).
package gray_arb_pkg;

    localparam int WIDTH_DEF = 4;

    typedef logic req_id_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder: each bit XORs with its upper neighbour,
// the MSB passes through (shifting in a zero covers the MSB and the WIDTH=1 case).
module gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    always_comb begin
        o_gray = i_bin ^ (i_bin >> 1);
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two requesters share one binary-to-Gray encoder; the registered result carries the winner's ID.
// Define GRAY_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_bin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_bin,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_id
);

    // Handshake: a word moves on any cycle where valid and ready are both high;
    // a requester must hold valid and data stable until it sees ready.

    out_state_t       r_state;
    out_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_gray;
    req_id_t          r_id;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    req_id_t          w_sel_id;
    logic [WIDTH-1:0] w_sel_bin;
    logic [WIDTH-1:0] w_sel_gray;

`ifdef GRAY_ARB_RR_EN
    req_id_t r_last_grant;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        w_grant0 = req0_valid & (~req1_valid | (r_last_grant == 1'b1));
        w_grant1 = req1_valid & (~req0_valid | (r_last_grant == 1'b0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_sel_id;
        end
    end
`else
    always_comb begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid & ~req0_valid;
    end
`endif

    always_comb begin
        w_can_accept = (r_state == EMPTY) | out_ready;
        req0_ready   = w_grant0 & w_can_accept & ~rst;
        req1_ready   = w_grant1 & w_can_accept & ~rst;
        w_accept     = req0_ready | req1_ready;
        w_sel_id     = w_grant1;
        w_sel_bin    = w_grant1 ? req1_bin : req0_bin;
    end

    gray_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .i_bin  (w_sel_bin),
        .o_gray (w_sel_gray)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_nxt = FULL;
            FULL: begin
                if (w_accept) begin
                    w_state_nxt = FULL;
                end else if (out_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_gray  <= '0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_gray <= w_sel_gray;
                r_id   <= w_sel_id;
            end
        end
    end

    always_comb begin
        out_valid = (r_state == FULL);
        out_gray  = r_gray;
        out_id    = r_id;
    end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

- Shares one binary-to-Gray conversion unit between two requesters using valid/ready handshakes.
- Arbitration is round-robin (fixed priority when configured out); the result is registered with the winner's ID.
- Sits in front of the code-converter datapath so several producers can use one encoder without contention.

## Interface
Parameters:
- WIDTH, 4, bit width of the binary input and Gray output

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 presents a binary word
- req0_bin  input  WIDTH  requester 0 binary word
- req0_ready  output  1  requester 0 word accepted this cycle
- req1_valid  input  1  requester 1 presents a binary word
- req1_bin  input  WIDTH  requester 1 binary word
- req1_ready  output  1  requester 1 word accepted this cycle
- out_valid  output  1  out_gray/out_id hold a result
- out_ready  input  1  consumer takes the result
- out_gray  output  WIDTH  Gray code of the accepted word
- out_id  output  1  requester that produced out_gray (0/1)

## Operation
- Conversion: gray[WIDTH-1] = bin[WIDTH-1]; gray[i] = bin[i+1] ^ bin[i] for i < WIDTH-1. Pure bitwise, no carries, width preserved.
- Output register has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY when out_ready and no accept.
  - FULL→FULL when out_ready and accept (reload, back-to-back).
  - FULL holds unchanged while out_ready=0.
- can_accept = (state==EMPTY) | out_ready.
- Grant, combinational from the valids and last_grant:
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ last_grant wins.
- reqN_ready = grantN & can_accept. The ready of a non-valid requester is 0. At most one ready is high per cycle.
- Accept = valid & ready for the granted port. On accept:
  - out_gray ← encode(reqN_bin), out_id ← N
  - last_grant ← N
- last_grant updates only on accept, never on a stalled grant.
- A granted but stalled requester must hold valid and data (AXI-style). The grant may move to the other requester if it raises valid and last_grant favours it; the arbiter does not lock a stalled winner.
- Reset values:
  - out_valid=0, out_gray=0, out_id=0
  - last_grant=1, so req0 wins the first simultaneous contention
  - req0_ready=0, req1_ready=0 while rst is high

## Timing
- Latency: word accepted at edge N appears on out_gray/out_valid after edge N, i.e. valid in cycle N+1.
- Throughput: one word per cycle while out_ready=1.
- out_gray/out_id are stable while out_valid=1 and out_ready=0.
- Simultaneous drain and accept in one cycle: the new result replaces the old with no bubble.
- rst asserted mid-operation: a pending result is discarded, state returns to EMPTY at the next edge, and no ready is asserted in the reset cycle.
- WIDTH=1: out_gray equals the input bit.
- All-ones input gives MSB-only Gray (4'b1111→4'b1000).

## Configuration
- GRAY_ARB_RR_EN defined: round-robin as above, using the last_grant register.
- GRAY_ARB_RR_EN undefined:
  - Fixed priority: req0 always wins when both are valid.
  - last_grant register is absent.
  - req1 is served only when req0_valid=0.

## Structure
- Package gray_arb_pkg:
  - WIDTH default constant
  - req_id_t (1-bit requester ID)
  - out_state_t enum {EMPTY, FULL}
- Sub-module gray_enc: combinational WIDTH-bit binary→Gray encoder, instantiated once after the grant mux.
- Top module holds:
  - arbiter logic
  - grant mux
  - output register/state machine

## Test plan
- Reset with both valid and out_ready=1, then release rst → both readys are 0 in the reset cycle; req0 is accepted first.
- Single requester, req0_bin = 4'b1000, 4'b0110, 4'b0101, 4'b0001 on consecutive cycles with out_ready=1 → out_gray = 1100, 0101, 0111, 0001 with out_id=0, one per cycle.
- Both requesters continuously valid (req0=4'b0011, req1=4'b1111), out_ready=1, RR build:
  - out_id alternates 0,1,0,1.
  - out_gray alternates 0010, 1000.
  - Fixed build: out_id stays 0.
- Backpressure: out_ready=0 for 3 cycles after 4'b0111 is accepted:
  - out_gray holds 0100.
  - Both readys stay 0.
  - Raising out_ready loads the next word in the same cycle.
- Reset mid-stream while out_valid=1 and out_ready=0 → out_valid=0 and out_gray=0 on the next cycle; the pending result is lost.
- Stalled winner: req1 waiting under out_ready=0 while req0 rises and last_grant=1 → req0 is granted once out_ready rises.
